// File: rtl/crc_code_pkg.sv
// Shared definitions for the CRC-4 (x^4 + x + 1) codeword encoder and decoder.
// The LFSR step lives here so both directions use one recurrence.
package crc_code_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CRC_WIDTH  = 4;
  localparam int CODE_WIDTH = DATA_WIDTH + CRC_WIDTH;

  // x^4 + x + 1, MSB is the implicit x^4 term
  localparam logic [CRC_WIDTH:0] CRC4_POLY = 5'b10011;

  // Value of bit_cnt during the final (12th) shift
  localparam logic [3:0] LAST_SHIFT = 4'(CODE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One bit-serial division step: shift the remainder up, bring in the next
  // message bit, and subtract (xor) the polynomial when x^3 falls out.
  // Equivalent to {lfsr[2], lfsr[1], lfsr[3]^lfsr[0], lfsr[3]^din}.
  function automatic logic [CRC_WIDTH-1:0] crc4_step(
    input logic [CRC_WIDTH-1:0] lfsr,
    input logic                 din
  );
    logic [CRC_WIDTH-1:0] shifted;
    shifted = {lfsr[CRC_WIDTH-2:0], din};
    return shifted ^ ({CRC_WIDTH{lfsr[CRC_WIDTH-1]}} & CRC4_POLY[CRC_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/crc_code_encoder.sv
// Serial CRC-4 encoder: takes one byte, shifts {data, 4'b0} through the
// remainder LFSR over 12 cycles and presents the codeword {data, crc}.
//
// Handshake: start is a request that is taken only on a clock edge where
// ready=1 (state IDLE); data_in is captured on that same edge. Requests while
// busy are dropped, not queued. encoded_valid is a one-cycle pulse with no
// backpressure: the consumer must take encoded_data in that cycle. After the
// pulse the codeword stays on encoded_data until the next accepted start.
module crc_code_encoder
  import crc_code_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic [CODE_WIDTH-1:0] encoded_data,
  output logic                  encoded_valid
);

  state_t                state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CODE_WIDTH-1:0] shift_reg;
  logic [CRC_WIDTH-1:0]  lfsr;
  logic [3:0]            bit_cnt;

  // Sequencer: capture on accepted start, run 12 shifts, hold one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_reg  <= '0;
      shift_reg <= '0;
      lfsr      <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_reg  <= data_in;
            shift_reg <= {data_in, {CRC_WIDTH{1'b0}}};
            lfsr      <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr      <= crc4_step(lfsr, shift_reg[CODE_WIDTH-1]);
          shift_reg <= shift_reg << 1;
          // Counter stops at 11 so it never leaves the 0..11 range
          if (bit_cnt == LAST_SHIFT) begin
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          // Unused encoding 2'd3 falls back to IDLE
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore output decode straight from the state and data registers.
  always_comb begin
    ready         = (state == IDLE);
    busy          = !ready;
    encoded_valid = (state == DONE);
    encoded_data  = {data_reg, lfsr};
  end

endmodule

// File: tb/tb_crc_code_encoder.sv
// Directed + random bench for crc_code_encoder. Expected codewords come from a
// polynomial long-division model; a decoder model checks remainders.
module tb_crc_code_encoder;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        start;
  logic        ready;
  logic        busy;
  logic [11:0] encoded_data;
  logic        encoded_valid;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  crc_code_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .start         (start),
    .ready         (ready),
    .busy          (busy),
    .encoded_data  (encoded_data),
    .encoded_valid (encoded_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Remainder of a 12-bit polynomial modulo x^4 + x + 1 by long division.
  function automatic logic [3:0] poly_mod(input logic [11:0] code);
    int r;
    r = int'(code);
    for (int i = 11; i >= 4; i--) begin
      if (r[i]) r = r ^ (32'h13 << (i - 4));
    end
    return r[3:0];
  endfunction

  function automatic logic [11:0] ref_code(input logic [7:0] d);
    logic [11:0] m;
    m = {d, 4'b0000};
    return {d, poly_mod(m)};
  endfunction

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("wait_ready", {11'd0, ready}, 12'd1);
  endtask

  // Encode one byte; optionally pulse a stray start with 8'hFF at cycles 3 and 10.
  task automatic encode(input logic [7:0] d, input bit interfere, output logic [11:0] got);
    int lat;
    logic [11:0] e;
    wait_ready();
    exp_q.push_back(ref_code(d));
    data_in = d;
    start   = 1'b1;
    tick();                       // accepting edge E0
    start   = 1'b0;
    lat     = 0;
    while (encoded_valid !== 1'b1 && lat < 20) begin
      if (interfere) begin
        check("ready_low_busy", {11'd0, ready}, 12'd0);
        if (lat == 3 || lat == 10) begin
          start   = 1'b1;
          data_in = 8'hFF;
        end else begin
          start = 1'b0;
        end
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("latency", 12'(lat), 12'd12);
    e   = exp_q.pop_front();
    got = encoded_data;
    check("codeword", encoded_data, e);
    check("busy_in_done", {11'd0, busy}, 12'd1);
    check("decoder_zero_rem", {8'd0, poly_mod(encoded_data)}, 12'd0);
    tick();
    check("pulse_width", {11'd0, encoded_valid}, 12'd0);
    check("ready_after_done", {11'd0, ready}, 12'd1);
    check("hold_after_done", encoded_data, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] got;
    logic [7:0]  dirs [4];
    logic [11:0] dir_exp [4];
    logic [7:0]  seq_d [5];
    logic [7:0]  rnd;
    logic [11:0] flipped;

    rst = 1'b1; start = 1'b0; data_in = 8'h00;
    tick(); tick();
    check("rst_ready", {11'd0, ready}, 12'd1);
    check("rst_busy", {11'd0, busy}, 12'd0);
    check("rst_valid", {11'd0, encoded_valid}, 12'd0);
    check("rst_data", encoded_data, 12'h000);
    rst = 1'b0;
    tick();

    // 1: basic latency and value
    encode(8'h01, 1'b0, got);
    check("enc_01", got, 12'h013);

    // 2: directed values with known codewords
    dirs    = '{8'h00, 8'h80, 8'hFF, 8'hA5};
    dir_exp = '{12'h000, 12'h80E, 12'hFF4, 12'hA5B};
    for (int i = 0; i < 4; i++) begin
      encode(dirs[i], 1'b0, got);
      check("enc_known", got, dir_exp[i]);
    end

    // 3: stray starts while busy are ignored
    encode(8'h01, 1'b1, got);
    check("enc_ignore_start", got, 12'h013);

    // 4: reset in the middle of SHIFT
    wait_ready();
    data_in = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", {11'd0, ready}, 12'd1);
    check("midrst_busy", {11'd0, busy}, 12'd0);
    check("midrst_data", encoded_data, 12'h000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("midrst_no_pulse", {11'd0, encoded_valid}, 12'd0);
    end
    encode(8'hA5, 1'b0, got);
    check("enc_after_rst", got, 12'hA5B);

    // 6: every single-bit error in a DUT codeword leaves a nonzero remainder
    for (int b = 0; b < 12; b++) begin
      flipped = got ^ (12'd1 << b);
      check("flip_detect", {11'd0, (poly_mod(flipped) != 4'd0)}, 12'd1);
    end

    // 5: start held high, alternating payload, one codeword per 14 cycles
    seq_d = '{8'h80, 8'hFF, 8'h80, 8'hFF, 8'h80};
    wait_ready();
    start = 1'b1; data_in = seq_d[0];
    tick();                       // first accept
    for (int k = 0; k < 4; k++) begin
      data_in = seq_d[k + 1];     // ignored while busy, taken at next accept
      for (int c = 1; c <= 14; c++) begin
        tick();
        if (c < 12) check("b2b_no_valid", {11'd0, encoded_valid}, 12'd0);
        if (c == 12) begin
          check("b2b_valid", {11'd0, encoded_valid}, 12'd1);
          check("b2b_code", encoded_data, ref_code(seq_d[k]));
        end
        if (c == 13) begin
          check("b2b_idle_ready", {11'd0, ready}, 12'd1);
          check("b2b_hold", encoded_data, ref_code(seq_d[k]));
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();

    // random payloads against the division model
    for (int i = 0; i < 24; i++) begin
      rnd = 8'($urandom_range(0, 255));
      encode(rnd, 1'b0, got);
      check("rand_code", got, ref_code(rnd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
